// File: rtl/sifh_pkg.sv
// Shared definitions for the SiFH histogram sequencer: FSM state encoding,
// default sizing constants and the saturating bin increment.
package sifh_pkg;

  localparam int SIFH_NP      = 10;
  localparam int SIFH_ADDR_W  = 10;
  localparam int SIFH_CNT_W   = 8;
  localparam int SIFH_ACQ_NUM = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACC,
    ST_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_DONE
  } sifh_seq_state_t;

  // value + 1, clamped at the all-ones value of a 'width'-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/sifh_hist_sequencer_if.sv
// Bundle of the sequencer's timestamp stream, both SRAM ports and the
// readout stream.
//
// Handshakes (ts_*, rd_*): a beat transfers on a rising clk edge where
// valid & ready are both high. The source keeps valid and its data stable
// until the transfer; ready may change freely and never depends on
// combinationally sampling the same beat's data.
interface sifh_hist_sequencer_if import sifh_pkg::*; #(
  parameter int NP     = SIFH_NP,
  parameter int ADDR_W = SIFH_ADDR_W,
  parameter int CNT_W  = SIFH_CNT_W
);
  logic              start;
  logic              ts_valid;
  logic [NP-1:0]     ts_data;
  logic              ts_ready;
  logic              ram_me_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [CNT_W-1:0]  ram_q_a;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [CNT_W-1:0]  ram_d_b;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_bin;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_ready;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, ts_valid, ts_data, ram_q_a, rd_ready,
    output ts_ready, ram_me_a, ram_addr_a, ram_we_b, ram_addr_b, ram_d_b,
           rd_valid, rd_bin, rd_count, busy, frame_done
  );

  modport slave (
    output start, ts_valid, ts_data, ram_q_a, rd_ready,
    input  ts_ready, ram_me_a, ram_addr_a, ram_we_b, ram_addr_b, ram_d_b,
           rd_valid, rd_bin, rd_count, busy, frame_done
  );
endinterface

// File: rtl/sifh_rmw_pipe.sv
// Read-modify-write accumulation pipeline: accept -> read -> increment ->
// write, with forwarding from the write stage and the previous write so
// same-bin hits one or two cycles apart still count exactly.
module sifh_rmw_pipe import sifh_pkg::*; #(
  parameter int ADDR_W = SIFH_ADDR_W,
  parameter int CNT_W  = SIFH_CNT_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              accept,
  input  logic [ADDR_W-1:0] bin,
  input  logic [CNT_W-1:0]  ram_q_a,
  output logic              me_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [CNT_W-1:0]  d_b
);
  logic              s1_valid, s2_valid, w_valid, last_valid;
  logic [ADDR_W-1:0] s1_bin, s2_bin, w_bin, last_bin;
  logic [CNT_W-1:0]  w_data, last_data;
  logic [CNT_W-1:0]  old_val, new_val;

  // Pick the freshest copy of the bin: the write in flight, then the write
  // that just landed (SRAM read returned pre-write data), then the SRAM.
  always_comb begin
    old_val = ram_q_a;
    if (w_valid && (w_bin == s2_bin)) begin
      old_val = w_data;
    end else if (last_valid && (last_bin == s2_bin)) begin
      old_val = last_data;
    end
    new_val = CNT_W'(sat_inc(32'(old_val), CNT_W));
  end

  // Stage registers; last_* tracks only the immediately preceding cycle's write
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_valid   <= 1'b0;
      s1_bin     <= '0;
      s2_valid   <= 1'b0;
      s2_bin     <= '0;
      w_valid    <= 1'b0;
      w_bin      <= '0;
      w_data     <= '0;
      last_valid <= 1'b0;
      last_bin   <= '0;
      last_data  <= '0;
    end else begin
      s1_valid   <= accept;
      s1_bin     <= bin;
      s2_valid   <= s1_valid;
      s2_bin     <= s1_bin;
      w_valid    <= s2_valid;
      w_bin      <= s2_bin;
      w_data     <= new_val;
      last_valid <= w_valid;
      last_bin   <= w_bin;
      last_data  <= w_data;
    end
  end

  assign me_a   = s1_valid;
  assign addr_a = s1_bin;
  assign we_b   = w_valid;
  assign addr_b = w_bin;
  assign d_b    = w_data;
endmodule

// File: rtl/sifh_hist_sequencer.sv
// Frame controller for the SiFH histogram SRAM: clear all bins, accumulate
// ACQ_NUM timestamps through the RMW pipeline, then stream every bin out.
module sifh_hist_sequencer import sifh_pkg::*; #(
  parameter int NP      = SIFH_NP,
  parameter int ADDR_W  = SIFH_ADDR_W,
  parameter int CNT_W   = SIFH_CNT_W,
  parameter int ACQ_NUM = SIFH_ACQ_NUM
) (
  input  logic                  clk,
  input  logic                  res,
  sifh_hist_sequencer_if.master bus,
  output sifh_seq_state_t       dbg_state
);
  localparam int                ACC_W     = $clog2(ACQ_NUM + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(ACQ_NUM - 1);
  localparam logic [ACC_W-1:0]  ACC_FULL  = ACC_W'(ACQ_NUM);

  sifh_seq_state_t   state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, rd_idx;
  logic [ACC_W-1:0]  acc_cnt;
  logic [1:0]        drain_cnt;
  logic [CNT_W-1:0]  rd_cap;
  logic              accept;
  logic              pipe_me_a, pipe_we_b;
  logic [ADDR_W-1:0] pipe_addr_a, pipe_addr_b;
  logic [CNT_W-1:0]  pipe_d_b;

  assign bus.ts_ready = (state == ST_ACC) && (acc_cnt < ACC_FULL);
  assign accept       = bus.ts_valid & bus.ts_ready;

  sifh_rmw_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_pipe (
    .clk     (clk),
    .res     (res),
    .accept  (accept),
    .bin     (bus.ts_data[NP-1 -: ADDR_W]),
    .ram_q_a (bus.ram_q_a),
    .me_a    (pipe_me_a),
    .addr_a  (pipe_addr_a),
    .we_b    (pipe_we_b),
    .addr_b  (pipe_addr_b),
    .d_b     (pipe_d_b)
  );

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.start) state_nxt = ST_CLEAR;
      ST_CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = ST_ACC;
      ST_ACC:     if (accept && (acc_cnt == ACC_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt == 2'd2) state_nxt = ST_RD_REQ;
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = ST_RD_OUT;
      ST_RD_OUT:  if (bus.rd_ready) state_nxt = (rd_idx == LAST_ADDR) ? ST_DONE : ST_RD_REQ;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Clear, accept, drain and readout counters plus the readout data capture
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      clr_cnt   <= '0;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      rd_idx    <= '0;
      rd_cap    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_cnt   <= '0;
          acc_cnt   <= '0;
          drain_cnt <= '0;
          rd_idx    <= '0;
        end
        ST_CLEAR:   clr_cnt <= clr_cnt + 1'b1;
        ST_ACC:     if (accept) acc_cnt <= acc_cnt + 1'b1;
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          rd_idx    <= '0;
        end
        ST_RD_WAIT: rd_cap <= bus.ram_q_a;
        ST_RD_OUT:  if (bus.rd_ready) rd_idx <= rd_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // SRAM port ownership: CLEAR and readout borrow the ports while the pipe is idle
  always_comb begin
    bus.ram_me_a   = pipe_me_a;
    bus.ram_addr_a = pipe_addr_a;
    bus.ram_we_b   = pipe_we_b;
    bus.ram_addr_b = pipe_addr_b;
    bus.ram_d_b    = pipe_d_b;
    if (state == ST_CLEAR) begin
      bus.ram_we_b   = 1'b1;
      bus.ram_addr_b = clr_cnt;
      bus.ram_d_b    = '0;
    end
    if (state == ST_RD_REQ) begin
      bus.ram_me_a   = 1'b1;
      bus.ram_addr_a = rd_idx;
    end
  end

  assign bus.rd_valid   = (state == ST_RD_OUT);
  assign bus.rd_bin     = rd_idx;
  assign bus.rd_count   = rd_cap;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = (state == ST_DONE);
  assign dbg_state      = state;
endmodule

// File: tb/tb_sifh_hist_sequencer.sv
// Bench for sifh_hist_sequencer: SRAM model, timestamp/readout drivers and a
// histogram reference model feeding an expected readout queue.
module tb_sifh_hist_sequencer;
  import sifh_pkg::*;

  localparam int NP      = 4;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 3;
  localparam int ACQ_NUM = 8;
  localparam int NBINS   = 1 << ADDR_W;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int W       = ADDR_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sifh_seq_state_t dbg_state;
  sifh_hist_sequencer_if #(.NP(NP), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  sifh_hist_sequencer #(.NP(NP), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ACQ_NUM(ACQ_NUM)) dut (
    .clk       (clk),
    .res       (res),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model: 1-cycle read, old data on collision ----------------
  logic [CNT_W-1:0] mem [NBINS];
  logic preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NBINS; i++) mem[i] <= CNT_W'(5);
    end else if (bus.ram_we_b) begin
      mem[bus.ram_addr_b] <= bus.ram_d_b;
    end
    if (bus.ram_me_a) bus.ram_q_a <= mem[bus.ram_addr_a];
  end

  wire [31:0] out_vec = 32'({bus.busy, bus.ts_ready, bus.ram_me_a, bus.ram_we_b,
                             bus.rd_valid, bus.frame_done, bus.rd_bin, bus.rd_count,
                             bus.ram_addr_a, bus.ram_addr_b, bus.ram_d_b});

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int model_hist [NBINS];
  int bin_q [$];
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic start_frame();
    int good;
    for (int i = 0; i < NBINS; i++) model_hist[i] = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    good = 0;
    for (int i = 0; i < NBINS; i++) begin
      if (bus.ram_we_b && (bus.ram_addr_b == ADDR_W'(i)) && (bus.ram_d_b == '0)) good++;
      @(negedge clk);
    end
    check("clear_writes", good, NBINS);
    check("acc_ready", bus.ts_ready, 1);
  endtask

  task automatic drive_ts(input bit full_rate, input int n_exp);
    int cycles;
    int b;
    cycles = 0;
    while (bin_q.size() > 0 && cycles < 400) begin
      cycles++;
      bus.start = full_rate ? 1'b0 : 1'($urandom_range(0, 1));
      if (full_rate || $urandom_range(0, 2) != 0) begin
        bus.ts_valid = 1'b1;
        bus.ts_data  = NP'(bin_q[0]) << (NP - ADDR_W);
      end else begin
        bus.ts_valid = 1'b0;
        bus.ts_data  = NP'($urandom);
      end
      if (bus.ts_valid && bus.ts_ready) begin
        b = bin_q.pop_front();
        if (model_hist[b] < CMAX) model_hist[b]++;
      end
      @(negedge clk);
    end
    bus.ts_valid = 1'b0;
    bus.start    = 1'b0;
    check("ts_all_accepted", bin_q.size(), 0);
    if (full_rate) check("ts_full_rate_cycles", cycles, n_exp);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall bin 4 for 5 cycles
  task automatic readout(input int mode);
    logic         held_valid;
    logic [W-1:0] held, got, exp;
    int           stall_left, guard, done_seen;
    for (int b = 0; b < NBINS; b++) exp_q.push_back({ADDR_W'(b), CNT_W'(model_hist[b])});
    check("drain_ready_low", bus.ts_ready, 0);
    held_valid = 1'b0;
    held       = '0;
    stall_left = 5;
    guard      = 0;
    done_seen  = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      guard++;
      case (mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = 1'($urandom_range(0, 1));
        default: bus.rd_ready = !(bus.rd_valid && (bus.rd_bin == ADDR_W'(4)) && stall_left > 0);
      endcase
      if (mode == 2 && !bus.rd_ready) stall_left--;
      got = {bus.rd_bin, bus.rd_count};
      if (held_valid) check("rd_hold", {bus.rd_valid, got}, {1'b1, held});
      if (bus.frame_done) done_seen++;
      held_valid = bus.rd_valid && !bus.rd_ready;
      held       = got;
      if (bus.rd_valid && bus.rd_ready) begin
        exp = exp_q.pop_front();
        check($sformatf("rd_bin%0d", exp[W-1 -: ADDR_W]), got, exp);
      end
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
    check("rd_timeout", exp_q.size(), 0);
    check("frame_done_early", done_seen, 0);
    if (mode == 2) check("rd_stall_cycles", 5 - stall_left, 5);
    check("frame_done_pulse", bus.frame_done, 1);
    @(negedge clk);
    check("frame_done_clear", bus.frame_done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic random_bins(input int n, input int max_bin);
    bin_q.delete();
    for (int i = 0; i < n; i++) bin_q.push_back($urandom_range(0, max_bin));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start    = 1'b0;
    bus.ts_valid = 1'b0;
    bus.ts_data  = '0;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec, 0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    res = 1'b0;
    @(negedge clk);
    check("idle_after_reset", bus.busy, 0);

    // same bin at full rate, saturating on the eighth hit
    start_frame();
    bin_q = {3, 3, 3, 3, 3, 3, 3, 3};
    drive_ts(1'b1, ACQ_NUM);
    readout(0);

    // alternating bins: forwarding at distances 1 and 2
    start_frame();
    bin_q = {1, 2, 1, 2, 1, 1, 2, 1};
    drive_ts(1'b1, ACQ_NUM);
    readout(1);

    // random gaps, stray start pulses, readout stall on bin 4
    start_frame();
    random_bins(ACQ_NUM, NBINS - 1);
    drive_ts(1'b0, ACQ_NUM);
    readout(2);

    // reset during ACC with writes still in flight
    start_frame();
    bin_q = {5, 5, 9, 2};
    drive_ts(1'b1, 4);
    res = 1'b1;
    #1;
    check("midop_reset_outputs", out_vec, 0);
    check("midop_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    start_frame();
    random_bins(ACQ_NUM, 3);
    drive_ts(1'b1, ACQ_NUM);
    readout(0);

    // dense collisions with random valid and ready
    repeat (3) begin
      start_frame();
      random_bins(ACQ_NUM, 2);
      drive_ts(1'b0, ACQ_NUM);
      readout(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
